dat_read_sequencer: RTL and testbench
=====================================

// Module: dat_read_sequencer
// PURPOSE
//   Sequences single- and multi-block SD reads on the DAT-receive datapath (dat_read).
//   Arms one block at a time, enforces buffer back-pressure at block gaps, runs the data timeout,
//   counts blocks and reports completion/errors to the host register file as 1-cycle pulses.
// PARAMETERS
//   BlockCountWidth  16  width of block count / blocks-done counter
//   TimeoutWidth     28  width of timeout counter (max limit 2^27 SD clocks)
// PORTS
//   clk_i             in   1   system clock
//   rst_ni            in   1   asynchronous active-low reset
//   sd_clk_en_i       in   1   SD clock tick enable (one clk_i cycle per SD clock)
//   xfer_start_i      in   1   pulse: begin read transfer (ignored unless IDLE)
//   abort_i           in   1   pulse: abandon transfer immediately
//   stop_at_gap_i     in   1   level: finish current block, then complete
//   block_count_en_i  in   1   1: stop after block_count_i blocks; 0: unbounded until stop_at_gap_i
//   block_count_i     in   BlockCountWidth  blocks to read (sampled on xfer_start_i)
//   timeout_ctrl_i    in   4   limit = 2^(13+timeout_ctrl_i) SD ticks; 15 treated as 14
//   buf_space_i       in   1   level: host buffer can accept one full block
//   dat_start_o       out  1   to dat_read.start_i
//   dat_timeout_o     out  1   to dat_read.timeout_i
//   dat_waiting_i     in   1   from dat_read.waiting_o
//   dat_done_i        in   1   from dat_read.done_o
//   dat_crc_err_i     in   1   from dat_read.crc_err_o (valid with dat_done_i)
//   dat_end_err_i     in   1   from dat_read.end_bit_err_o (valid with dat_done_i)
//   busy_o            out  1   transfer active (not IDLE)
//   blocks_done_o     out  BlockCountWidth  blocks completed without error this transfer
//   xfer_complete_o   out  1   pulse: transfer ended successfully or via stop_at_gap_i
//   crc_err_o         out  1   pulse: data CRC error
//   end_bit_err_o     out  1   pulse: end-bit error
//   timeout_err_o     out  1   pulse: data timeout
// BEHAVIOUR
//   Reset: state IDLE, all outputs 0, counters 0. abort_i has priority over all events.
//   States: IDLE, WAIT_BUF, ARM, RECEIVE, GAP, ERROR.
//   IDLE: on xfer_start_i latch count/enable, clear blocks_done_o; if block_count_en_i && count==0
//     -> xfer_complete_o next cycle, stay IDLE; else -> WAIT_BUF.
//   WAIT_BUF: wait for buf_space_i && !stop_at_gap_i -> ARM; stop_at_gap_i -> complete, IDLE.
//   ARM: dat_start_o = 1 until a cycle with sd_clk_en_i (dat_read samples start on that tick) -> RECEIVE.
//   RECEIVE: timeout counter clears on ARM, increments on sd_clk_en_i while dat_waiting_i;
//     reaching limit -> dat_timeout_o and timeout_err_o pulse 1 cycle, -> ERROR.
//     dat_done_i: crc or end error -> pulse crc_err_o / end_bit_err_o (both if both), -> ERROR;
//     clean -> blocks_done_o += 1 (wraps at 2^BlockCountWidth), -> GAP.
//   GAP (1 cycle): remaining==0 with enable, or stop_at_gap_i -> xfer_complete_o, IDLE; else WAIT_BUF.
//   ERROR: busy_o stays 1; leaves only via abort_i -> IDLE. No xfer_complete_o after error.
//   Latency: clean done_i to xfer_complete_o = 2 cycles (GAP registered).
//   abort_i in any state: IDLE next cycle, no pulses, blocks_done_o held; dat_read must then be
//     software-reset by host (dat_read does not leave READY on its own).
//   xfer_start_i while busy ignored. Start and abort same cycle: abort wins.
// STRUCTURE
//   sdhci_pkg: state enum dat_seq_state_e, TimeoutBase = 13, TimeoutCtrlMax = 14.
//   Sub-module dat_timeout_cnt: clear/enable/tick inputs, limit select, 1-cycle expired pulse.
// TESTING
//   count_en=1, count=3, buf_space=1, clean blocks -> 3 dat_start_o, blocks_done_o=3, one complete.
//   count_en=1, count=0, start -> xfer_complete_o 1 cycle later, no dat_start_o.
//   buf_space=0 after block 1 for 50 cycles -> no dat_start_o until buf_space=1; then block 2 armed.
//   timeout_ctrl=0, dat_waiting held -> timeout_err_o + dat_timeout_o after 8192 ticks, ERROR.
//   block 2 done with crc_err=1 -> crc_err_o pulse, blocks_done_o=1, no complete; abort -> IDLE.
//   count_en=0, stop_at_gap raised mid block 4 -> block 4 finishes, blocks_done_o=4, complete.

Source files
------------

// File: rtl/sdhci_pkg.sv
// Shared types and constants for the SD host DAT-path sequencing logic.
package sdhci_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_WAIT_BUF,
        SEQ_ARM,
        SEQ_RECEIVE,
        SEQ_GAP,
        SEQ_ERROR
    } dat_seq_state_e;

    localparam int unsigned TimeoutBase    = 13;
    localparam int unsigned TimeoutCtrlMax = 14;

    // Encoding 15 is reserved by the host controller and behaves like 14.
    function automatic logic [3:0] clamp_timeout_ctrl(input logic [3:0] ctrl);
        return (ctrl > 4'(TimeoutCtrlMax)) ? 4'(TimeoutCtrlMax) : ctrl;
    endfunction

endpackage

// File: rtl/dat_timeout_cnt.sv
// Data timeout counter: counts enabled SD ticks and emits a one-cycle pulse
// when the selected power-of-two limit is reached.
module dat_timeout_cnt
    import sdhci_pkg::*;
#(
    parameter int Width = 28
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic       tick_i,
    input  logic [3:0] sel_i,
    output logic       expired_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_next;
    logic [Width-1:0] limit;
    logic [4:0]       shift;
    logic             expired_q;

    always_comb begin
        shift = 5'(TimeoutBase) + {1'b0, clamp_timeout_ctrl(sel_i)};
        limit = {{(Width-1){1'b0}}, 1'b1} << shift;
    end

    assign count_next = count_q + 1'b1;

    // The pulse fires only on the exact tick that hits the limit, so it cannot repeat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else if (clear_i) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else if (enable_i && tick_i) begin
            count_q   <= count_next;
            expired_q <= (count_next == limit);
        end else begin
            expired_q <= 1'b0;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/dat_read_sequencer.sv
// Sequences single/multi-block SD reads: arms dat_read one block at a time,
// honours buffer back-pressure at block gaps and reports status as pulses.
module dat_read_sequencer
    import sdhci_pkg::*;
#(
    parameter int BlockCountWidth = 16,
    parameter int TimeoutWidth    = 28
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       sd_clk_en_i,
    input  logic                       xfer_start_i,
    input  logic                       abort_i,
    input  logic                       stop_at_gap_i,
    input  logic                       block_count_en_i,
    input  logic [BlockCountWidth-1:0] block_count_i,
    input  logic [3:0]                 timeout_ctrl_i,
    input  logic                       buf_space_i,
    output logic                       dat_start_o,
    output logic                       dat_timeout_o,
    input  logic                       dat_waiting_i,
    input  logic                       dat_done_i,
    input  logic                       dat_crc_err_i,
    input  logic                       dat_end_err_i,
    output logic                       busy_o,
    output logic [BlockCountWidth-1:0] blocks_done_o,
    output logic                       xfer_complete_o,
    output logic                       crc_err_o,
    output logic                       end_bit_err_o,
    output logic                       timeout_err_o
);

    dat_seq_state_e             state_q, state_d;
    logic [BlockCountWidth-1:0] count_q;
    logic                       count_en_q;
    logic [BlockCountWidth-1:0] blocks_done_q;
    logic                       complete_q, complete_d;
    logic                       crc_q, crc_d;
    logic                       end_q, end_d;
    logic                       latch_req;
    logic                       block_ok;
    logic                       expired;

    dat_timeout_cnt #(
        .Width(TimeoutWidth)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (state_q == SEQ_ARM),
        .enable_i  ((state_q == SEQ_RECEIVE) && dat_waiting_i),
        .tick_i    (sd_clk_en_i),
        .sel_i     (timeout_ctrl_i),
        .expired_o (expired)
    );

    always_comb begin
        state_d       = state_q;
        complete_d    = 1'b0;
        crc_d         = 1'b0;
        end_d         = 1'b0;
        latch_req     = 1'b0;
        block_ok      = 1'b0;
        dat_start_o   = 1'b0;
        dat_timeout_o = 1'b0;
        timeout_err_o = 1'b0;

        unique case (state_q)
            SEQ_IDLE: begin
                if (xfer_start_i) begin
                    latch_req = 1'b1;
                    if (block_count_en_i && (block_count_i == '0)) begin
                        complete_d = 1'b1;
                    end else begin
                        state_d = SEQ_WAIT_BUF;
                    end
                end
            end
            SEQ_WAIT_BUF: begin
                if (stop_at_gap_i) begin
                    complete_d = 1'b1;
                    state_d    = SEQ_IDLE;
                end else if (buf_space_i) begin
                    state_d = SEQ_ARM;
                end
            end
            SEQ_ARM: begin
                // dat_read only samples start on an SD tick, so hold it until one arrives.
                dat_start_o = 1'b1;
                if (sd_clk_en_i) begin
                    state_d = SEQ_RECEIVE;
                end
            end
            SEQ_RECEIVE: begin
                if (dat_done_i) begin
                    if (dat_crc_err_i || dat_end_err_i) begin
                        crc_d   = dat_crc_err_i;
                        end_d   = dat_end_err_i;
                        state_d = SEQ_ERROR;
                    end else begin
                        block_ok = 1'b1;
                        state_d  = SEQ_GAP;
                    end
                end else if (expired) begin
                    dat_timeout_o = 1'b1;
                    timeout_err_o = 1'b1;
                    state_d       = SEQ_ERROR;
                end
            end
            SEQ_GAP: begin
                if ((count_en_q && (blocks_done_q == count_q)) || stop_at_gap_i) begin
                    complete_d = 1'b1;
                    state_d    = SEQ_IDLE;
                end else begin
                    state_d = SEQ_WAIT_BUF;
                end
            end
            SEQ_ERROR: begin
                state_d = SEQ_ERROR;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase

        // Abort silences everything, including a start or a pulse decided this cycle.
        if (abort_i) begin
            state_d       = SEQ_IDLE;
            complete_d    = 1'b0;
            crc_d         = 1'b0;
            end_d         = 1'b0;
            latch_req     = 1'b0;
            block_ok      = 1'b0;
            dat_start_o   = 1'b0;
            dat_timeout_o = 1'b0;
            timeout_err_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= SEQ_IDLE;
            count_q       <= '0;
            count_en_q    <= 1'b0;
            blocks_done_q <= '0;
            complete_q    <= 1'b0;
            crc_q         <= 1'b0;
            end_q         <= 1'b0;
        end else begin
            state_q    <= state_d;
            complete_q <= complete_d;
            crc_q      <= crc_d;
            end_q      <= end_d;
            if (latch_req) begin
                count_q       <= block_count_i;
                count_en_q    <= block_count_en_i;
                blocks_done_q <= '0;
            end else if (block_ok) begin
                blocks_done_q <= blocks_done_q + 1'b1;
            end
        end
    end

    assign busy_o          = (state_q != SEQ_IDLE);
    assign blocks_done_o   = blocks_done_q;
    assign xfer_complete_o = complete_q;
    assign crc_err_o       = crc_q;
    assign end_bit_err_o   = end_q;

endmodule

// File: tb/tb_dat_read_sequencer.sv
// Directed self-checking bench for dat_read_sequencer; the bench plays the
// part of dat_read and the host, with hand-computed expectations.
module tb_dat_read_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd_clk_en = 1'b1;
    logic        xfer_start = 1'b0;
    logic        abort = 1'b0;
    logic        stop_at_gap = 1'b0;
    logic        block_count_en = 1'b0;
    logic [15:0] block_count = '0;
    logic [3:0]  timeout_ctrl = '0;
    logic        buf_space = 1'b0;
    logic        dat_start;
    logic        dat_timeout;
    logic        dat_waiting = 1'b0;
    logic        dat_done = 1'b0;
    logic        dat_crc_err = 1'b0;
    logic        dat_end_err = 1'b0;
    logic        busy;
    logic [15:0] blocks_done;
    logic        xfer_complete;
    logic        crc_err;
    logic        end_bit_err;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    int start_count = 0;
    int complete_count = 0;
    int crc_count = 0;
    int timeout_count = 0;

    always #5 clk = ~clk;

    dat_read_sequencer dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .sd_clk_en_i      (sd_clk_en),
        .xfer_start_i     (xfer_start),
        .abort_i          (abort),
        .stop_at_gap_i    (stop_at_gap),
        .block_count_en_i (block_count_en),
        .block_count_i    (block_count),
        .timeout_ctrl_i   (timeout_ctrl),
        .buf_space_i      (buf_space),
        .dat_start_o      (dat_start),
        .dat_timeout_o    (dat_timeout),
        .dat_waiting_i    (dat_waiting),
        .dat_done_i       (dat_done),
        .dat_crc_err_i    (dat_crc_err),
        .dat_end_err_i    (dat_end_err),
        .busy_o           (busy),
        .blocks_done_o    (blocks_done),
        .xfer_complete_o  (xfer_complete),
        .crc_err_o        (crc_err),
        .end_bit_err_o    (end_bit_err),
        .timeout_err_o    (timeout_err)
    );

    // Event counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (dat_start && sd_clk_en) start_count++;
        if (xfer_complete) complete_count++;
        if (crc_err) crc_count++;
        if (timeout_err) timeout_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic en, input logic [15:0] count);
        block_count_en = en;
        block_count    = count;
        xfer_start     = 1'b1;
        step();
        xfer_start     = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    // Acts as dat_read for one block: waits to be armed, receives, then reports done.
    task automatic applyStimulus(input logic crc, input logic endb, input int wait_cycles, input logic raise_stop);
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            if (dat_start && sd_clk_en) begin
                ok = 1;
                step();
                break;
            end
            step();
        end
        checkOutput("armed", 32'(ok), 32'd1);
        dat_waiting = 1'b1;
        for (int n = 0; n < wait_cycles; n++) begin
            if (raise_stop && n == 1) stop_at_gap = 1'b1;
            step();
        end
        dat_waiting = 1'b0;
        dat_done    = 1'b1;
        dat_crc_err = crc;
        dat_end_err = endb;
        step();
        dat_done    = 1'b0;
        dat_crc_err = 1'b0;
        dat_end_err = 1'b0;
    endtask

    initial begin
        int s0;
        int c0;
        bit seen;

        repeat (3) step();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_blocks", 32'(blocks_done), 32'd0);
        checkOutput("reset_start", 32'(dat_start), 32'd0);
        checkOutput("reset_pulses", {28'd0, xfer_complete, crc_err, end_bit_err, timeout_err}, 32'd0);
        rst_n = 1'b1;
        step();

        // Three clean blocks with buffer space always available.
        buf_space = 1'b1;
        s0 = start_count;
        c0 = complete_count;
        pulse_start(1'b1, 16'd3);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        for (int b = 0; b < 3; b++) applyStimulus(1'b0, 1'b0, 4, 1'b0);
        checkOutput("t1_no_early_complete", 32'(xfer_complete), 32'd0);
        step();
        checkOutput("t1_complete_latency", 32'(xfer_complete), 32'd1);
        checkOutput("t1_idle", 32'(busy), 32'd0);
        step();
        checkOutput("t1_complete_width", 32'(xfer_complete), 32'd0);
        checkOutput("t1_blocks", 32'(blocks_done), 32'd3);
        checkOutput("t1_starts", 32'(start_count - s0), 32'd3);
        checkOutput("t1_completes", 32'(complete_count - c0), 32'd1);

        // Zero-length counted transfer completes immediately without arming.
        s0 = start_count;
        pulse_start(1'b1, 16'd0);
        checkOutput("t2_complete", 32'(xfer_complete), 32'd1);
        checkOutput("t2_busy", 32'(busy), 32'd0);
        checkOutput("t2_blocks_cleared", 32'(blocks_done), 32'd0);
        step();
        checkOutput("t2_complete_width", 32'(xfer_complete), 32'd0);
        repeat (5) step();
        checkOutput("t2_starts", 32'(start_count - s0), 32'd0);

        // Back-pressure after block 1; a start while busy must be ignored.
        s0 = start_count;
        pulse_start(1'b1, 16'd3);
        applyStimulus(1'b0, 1'b0, 3, 1'b0);
        buf_space = 1'b0;
        seen = 0;
        for (int n = 0; n < 50; n++) begin
            if (n == 10) begin
                pulse_start(1'b1, 16'd0);
            end else begin
                step();
            end
            if (dat_start) seen = 1;
        end
        checkOutput("t3_no_arm_without_space", 32'(seen), 32'd0);
        checkOutput("t3_starts_held", 32'(start_count - s0), 32'd1);
        checkOutput("t3_busy_start_ignored", 32'(blocks_done), 32'd1);
        checkOutput("t3_still_busy", 32'(busy), 32'd1);
        buf_space = 1'b1;
        for (int b = 0; b < 2; b++) applyStimulus(1'b0, 1'b0, 2, 1'b0);
        step();
        checkOutput("t3_complete", 32'(xfer_complete), 32'd1);
        checkOutput("t3_blocks", 32'(blocks_done), 32'd3);
        checkOutput("t3_starts", 32'(start_count - s0), 32'd3);

        // Data timeout with the shortest limit of 8192 SD ticks.
        timeout_ctrl = 4'd0;
        pulse_start(1'b1, 16'd1);
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            if (dat_start && sd_clk_en) begin
                seen = 1;
                step();
                break;
            end
            step();
        end
        checkOutput("t4_armed", 32'(seen), 32'd1);
        dat_waiting = 1'b1;
        seen = 0;
        for (int n = 0; n < 8191; n++) begin
            step();
            if (timeout_err || dat_timeout) seen = 1;
        end
        checkOutput("t4_no_early_timeout", 32'(seen), 32'd0);
        step();
        checkOutput("t4_timeout_err", 32'(timeout_err), 32'd1);
        checkOutput("t4_dat_timeout", 32'(dat_timeout), 32'd1);
        step();
        dat_waiting = 1'b0;
        checkOutput("t4_timeout_width", 32'(timeout_err), 32'd0);
        checkOutput("t4_error_busy", 32'(busy), 32'd1);
        c0 = complete_count;
        repeat (10) step();
        checkOutput("t4_no_complete", 32'(complete_count - c0), 32'd0);
        do_abort();
        checkOutput("t4_abort_idle", 32'(busy), 32'd0);

        // CRC error on block 2, then abort.
        c0 = complete_count;
        pulse_start(1'b1, 16'd3);
        applyStimulus(1'b0, 1'b0, 2, 1'b0);
        applyStimulus(1'b1, 1'b0, 2, 1'b0);
        checkOutput("t5_crc_pulse", 32'(crc_err), 32'd1);
        checkOutput("t5_no_end_err", 32'(end_bit_err), 32'd0);
        checkOutput("t5_blocks", 32'(blocks_done), 32'd1);
        step();
        checkOutput("t5_crc_width", 32'(crc_err), 32'd0);
        repeat (10) step();
        checkOutput("t5_error_busy", 32'(busy), 32'd1);
        checkOutput("t5_no_complete", 32'(complete_count - c0), 32'd0);
        do_abort();
        checkOutput("t5_abort_idle", 32'(busy), 32'd0);
        checkOutput("t5_blocks_held", 32'(blocks_done), 32'd1);

        // End-bit error only.
        pulse_start(1'b1, 16'd1);
        applyStimulus(1'b0, 1'b1, 2, 1'b0);
        checkOutput("t5b_end_pulse", 32'(end_bit_err), 32'd1);
        checkOutput("t5b_no_crc", 32'(crc_err), 32'd0);
        do_abort();

        // Unbounded transfer stopped at the gap after block 4.
        s0 = start_count;
        c0 = complete_count;
        pulse_start(1'b0, 16'd2);
        for (int b = 0; b < 3; b++) applyStimulus(1'b0, 1'b0, 2, 1'b0);
        checkOutput("t6_past_count", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 4, 1'b1);
        step();
        stop_at_gap = 1'b0;
        checkOutput("t6_complete", 32'(xfer_complete), 32'd1);
        checkOutput("t6_blocks", 32'(blocks_done), 32'd4);
        checkOutput("t6_starts", 32'(start_count - s0), 32'd4);
        checkOutput("t6_idle", 32'(busy), 32'd0);

        // Start and abort in the same cycle: abort wins.
        xfer_start     = 1'b1;
        abort          = 1'b1;
        block_count_en = 1'b1;
        block_count    = 16'd2;
        step();
        xfer_start = 1'b0;
        abort      = 1'b0;
        checkOutput("t7_abort_wins", 32'(busy), 32'd0);
        checkOutput("t7_blocks_held", 32'(blocks_done), 32'd4);
        step();
        checkOutput("t7_no_complete", 32'(xfer_complete), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
